instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: the requesting side of the instruction-memory read interface. It holds the program counter, drives word addresses into the byte-addressed, combinational-read instruction memory, and captures each returned 32-bit word with its PC into a 2-entry queue. Decode drains the queue through a valid/ready handshake. It sits between instruction memory and decode and handles start, branch redirect, backpressure and end-of-program halt.

## Interface
- ADDRWIDTH, 32, PC and memory address width
- DATAWIDTH, 32, instruction width
- RESET_PC, 32'h0, PC loaded on reset
- END_ADDR, 32, first byte address past the program; fetch stops when PC >= END_ADDR
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; moves IDLE to FETCH
- imem_address  out  ADDRWIDTH  byte address to memory; always equals the PC register
- imem_read_write  out  1  memory direction; constant 0 (read)
- imem_data_out  in  DATAWIDTH  combinational read data for imem_address
- redirect_valid  in  1  branch/jump redirect request
- redirect_pc  in  ADDRWIDTH  redirect target
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst_data  out  DATAWIDTH  head instruction
- inst_pc  out  ADDRWIDTH  head PC
- busy  out  1  state is FETCH
- halted  out  1  state is HALT and queue empty

## Operation
- States: IDLE, FETCH, HALT. Reset enters IDLE.
- IDLE: no pushes. start=1 goes to FETCH. redirect ignored.
- FETCH, each cycle, in priority order:
  - redirect_valid=1: queue flushed (count to 0), PC <= {redirect_pc[ADDRWIDTH-1:2], 2'b00}, no push. A pop handshake in the same cycle still counts as accepted by decode; the entry is nonetheless gone.
  - PC >= END_ADDR: no push, go to HALT.
  - Otherwise push {PC, imem_data_out} when count<2, or when count==2 and a pop occurs this cycle; on push PC <= PC+4, modulo 2^ADDRWIDTH.
  - No push: PC and imem_address hold.
- HALT: no pushes. The queue drains normally. A redirect flushes the queue, loads the PC and returns to FETCH. start is ignored.
- Pop: inst_valid && inst_ready. The head advances and count decrements, unless a push happens in the same cycle.
- Queue: 2 entries, FIFO order. inst_data/inst_pc show the head. When empty they hold their last value, or 0 after reset.
- imem_read_write is never 1; data_in to memory is not driven by this block.
- Reset values: PC=RESET_PC, imem_address=RESET_PC, count=0, inst_valid=0, inst_data=0, inst_pc=0, busy=0, halted=0, state IDLE.
- Reset mid-operation: the queue is discarded and all outputs return to reset values on the next edge.

## Timing
- imem_address is a direct register output. imem_data_out is sampled at the same edge that advances the PC, giving zero-wait fetch.
- start sampled in cycle 0: busy=1 in cycle 1, first push at the end of cycle 1, inst_valid=1 in cycle 2 with inst_pc=RESET_PC.
- inst_ready held high: 1 instruction per cycle, steady state count=1.
- inst_ready low: the queue fills after 2 pushes, then the PC stalls. Releasing ready resumes 1/cycle with no bubble, because push-on-pop is allowed at count=2.
- Redirect sampled in cycle N: inst_valid=0 in cycle N+1. The first target instruction is valid in cycle N+2.
- Halt: the cycle with PC==END_ADDR in FETCH moves to HALT. halted rises in the first cycle the queue is empty in HALT.

## Test plan
- Reset, start with memory preloaded with 0x00940333, 0x413903b3, 0x035a02b3, 0x017b4e33, 0x019c1eb3, 0x01bd5f33, 0x00d67fb3, 0x00f768b3, ready=1 -> 8 consecutive valid beats, PCs 0x00..0x1C with matching data; then inst_valid=0, halted=1, busy=0.
- Same program with ready low for 5 cycles after start -> count saturates at 2 and imem_address holds 0x08. Releasing ready gives 0x00940333, 0x413903b3, 0x035a02b3 on consecutive cycles with no duplicates or gaps.
- Redirect to 0x12 while 2 entries are queued -> queue flushed, inst_valid=0 next cycle, then inst_pc=0x10, inst_data=0x019c1eb3.
- After halt, redirect to 0x1C -> returns to FETCH, delivers 0x00f768b3 at PC 0x1C, then halts again.
- Assert rst mid-stream with count=2 -> next cycle inst_valid=0, inst_data=0, inst_pc=0, imem_address=RESET_PC, state IDLE; a start before reset deassertion is ignored.
- start while in FETCH or HALT, and redirect while IDLE -> no effect on PC or queue.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the decode valid/ready queue head.
interface instr_fetch_if #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32
);
  logic [ADDRWIDTH-1:0] imem_address;
  logic                 imem_read_write;
  logic [DATAWIDTH-1:0] imem_data_out;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [DATAWIDTH-1:0] inst_data;
  logic [ADDRWIDTH-1:0] inst_pc;

  modport master (
    output imem_address, imem_read_write,
    input  imem_data_out,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_address, imem_read_write,
    output imem_data_out,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register driving a combinational-read memory, feeding
// a 2-entry FIFO drained by decode, with start / redirect / halt control.
module instr_fetch #(
  parameter int                   ADDRWIDTH = 32,
  parameter int                   DATAWIDTH = 32,
  parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0,
  parameter logic [ADDRWIDTH-1:0] END_ADDR  = ADDRWIDTH'(32)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 redirect_valid,
  input  logic [ADDRWIDTH-1:0] redirect_pc,
  output logic                 busy,
  output logic                 halted,
  instr_fetch_if.master        bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_e;

  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] pc_q, pc_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic [DATAWIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic                 busy_q, busy_d, halted_q, halted_d;
  logic                 pop, push, flush;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    head_pc_d   = head_pc_q;
    head_data_d = head_data_q;
    tail_pc_d   = tail_pc_q;
    tail_data_d = tail_data_q;
    flush       = 1'b0;
    push        = 1'b0;
    pop         = (cnt_q != 2'd0) && bus.inst_ready;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redirect_pc & ~ADDRWIDTH'(3);
        end else if (pc_q >= END_ADDR) begin
          state_d = S_HALT;
        end else if (cnt_q != 2'd2 || pop) begin
          // A full queue may still accept a word when decode pops in the same cycle.
          push = 1'b1;
          pc_d = pc_q + ADDRWIDTH'(4);
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = redirect_pc & ~ADDRWIDTH'(3);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_pc_d   = pc_q;
            head_data_d = bus.imem_data_out;
          end else begin
            tail_pc_d   = pc_q;
            tail_data_d = bus.imem_data_out;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          // Last entry leaving keeps the head registers so the outputs hold their value.
          if (cnt_q == 2'd2) begin
            head_pc_d   = tail_pc_q;
            head_data_d = tail_data_q;
          end
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            head_pc_d   = tail_pc_q;
            head_data_d = tail_data_q;
            tail_pc_d   = pc_q;
            tail_data_d = bus.imem_data_out;
          end else begin
            head_pc_d   = pc_q;
            head_data_d = bus.imem_data_out;
          end
        end
        default: ;
      endcase
    end

    busy_d   = (state_d == S_FETCH);
    halted_d = (state_d == S_HALT) && (cnt_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      cnt_q       <= 2'd0;
      head_pc_q   <= '0;
      head_data_q <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      head_pc_q   <= head_pc_d;
      head_data_q <= head_data_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  // Second slot is only observable through the head, so it needs no reset.
  always_ff @(posedge clk) begin
    tail_pc_q   <= tail_pc_d;
    tail_data_q <= tail_data_d;
  end

  assign bus.imem_address    = pc_q;
  assign bus.imem_read_write = 1'b0;
  assign bus.inst_valid      = (cnt_q != 2'd0);
  assign bus.inst_data       = head_data_q;
  assign bus.inst_pc         = head_pc_q;
  assign busy                = busy_q;
  assign halted              = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a queue-based reference.
module tb_instr_fetch;

  localparam logic [31:0] END_A = 32'd32;

  logic        clk = 1'b0;
  logic        rst, start, redirect_valid, busy, halted;
  logic [31:0] redirect_pc;
  logic [31:0] mem [16];
  logic [31:0] prog [8];

  instr_fetch_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) bus ();

  instr_fetch #(.ADDRWIDTH(32), .DATAWIDTH(32), .RESET_PC(32'h0), .END_ADDR(END_A)) dut (
    .clk(clk), .rst(rst), .start(start), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy), .halted(halted), .bus(bus)
  );

  assign bus.imem_data_out = mem[bus.imem_address[5:2]];

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: mode 0=idle 1=fetch 2=halt; queue entries are {pc, data}.
  int          m_mode;
  logic [31:0] m_pc, m_show_pc, m_show_data;
  logic [63:0] m_q [$];
  logic [31:0] beat_pc [$];
  logic [31:0] beat_data [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_q.delete(); m_show_pc = 0; m_show_data = 0;
  endtask

  // Check the current outputs, advance the reference by one cycle, then clock.
  task automatic cyc();
    bit pop;
    if (m_q.size() > 0) begin
      m_show_pc   = m_q[0][63:32];
      m_show_data = m_q[0][31:0];
    end
    chk("imem_address", bus.imem_address, m_pc);
    chk("imem_read_write", 32'(bus.imem_read_write), 32'd0);
    chk("inst_valid", 32'(bus.inst_valid), 32'(m_q.size() > 0));
    chk("inst_pc", bus.inst_pc, m_show_pc);
    chk("inst_data", bus.inst_data, m_show_data);
    chk("busy", 32'(busy), 32'(m_mode == 1));
    chk("halted", 32'(halted), 32'(m_mode == 2 && m_q.size() == 0));
    if (bus.inst_valid && bus.inst_ready) begin
      beat_pc.push_back(bus.inst_pc);
      beat_data.push_back(bus.inst_data);
    end
    pop = (m_q.size() > 0) && bus.inst_ready;
    if (rst) begin
      model_reset();
    end else begin
      if (pop) void'(m_q.pop_front());
      case (m_mode)
        0: if (start) m_mode = 1;
        1: begin
          if (redirect_valid) begin
            m_q.delete();
            m_pc = redirect_pc & ~32'h3;
          end else if (m_pc >= END_A) begin
            m_mode = 2;
          end else if (m_q.size() < 2) begin
            m_q.push_back({m_pc, mem[m_pc[5:2]]});
            m_pc = m_pc + 32'd4;
          end
        end
        default: if (redirect_valid) begin
          m_q.delete();
          m_pc   = redirect_pc & ~32'h3;
          m_mode = 1;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    prog[0] = 32'h00940333; prog[1] = 32'h413903b3; prog[2] = 32'h035a02b3; prog[3] = 32'h017b4e33;
    prog[4] = 32'h019c1eb3; prog[5] = 32'h01bd5f33; prog[6] = 32'h00d67fb3; prog[7] = 32'h00f768b3;
    for (int i = 0; i < 16; i++) mem[i] = (i < 8) ? prog[i] : $urandom;
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; bus.inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cyc();
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_addr", bus.imem_address, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Straight run with decode always ready.
    rst = 1'b0; bus.inst_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    beat_pc.delete(); beat_data.delete();
    repeat (12) cyc();
    chk("t1_nbeats", 32'(beat_pc.size()), 32'd8);
    for (int i = 0; i < 8 && i < beat_pc.size(); i++) begin
      chk("t1_beat_pc", beat_pc[i], 32'(i * 4));
      chk("t1_beat_data", beat_data[i], prog[i]);
    end
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_valid", 32'(bus.inst_valid), 32'd0);

    // Backpressure: queue fills, PC stalls, release gives back-to-back beats.
    rst = 1'b1; cyc(); rst = 1'b0;
    bus.inst_ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    chk("t2_addr_stall", bus.imem_address, 32'h8);
    chk("t2_valid", 32'(bus.inst_valid), 32'd1);
    beat_pc.delete(); beat_data.delete();
    bus.inst_ready = 1'b1;
    repeat (3) cyc();
    chk("t2_nbeats", 32'(beat_pc.size()), 32'd3);
    for (int i = 0; i < 3 && i < beat_pc.size(); i++) begin
      chk("t2_beat_pc", beat_pc[i], 32'(i * 4));
      chk("t2_beat_data", beat_data[i], prog[i]);
    end

    // Redirect with two entries queued; target is word-aligned.
    bus.inst_ready = 1'b0;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h12;
    cyc();
    redirect_valid = 1'b0;
    chk("t3_flush_valid", 32'(bus.inst_valid), 32'd0);
    cyc();
    chk("t3_tgt_valid", 32'(bus.inst_valid), 32'd1);
    chk("t3_tgt_pc", bus.inst_pc, 32'h10);
    chk("t3_tgt_data", bus.inst_data, 32'h019c1eb3);

    // Run to halt, ignore start in HALT, then redirect back for one more word.
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 30 && !halted; i++) cyc();
    chk("t4_halted", 32'(halted), 32'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t4_start_ignored", 32'(halted), 32'd1);
    chk("t4_addr", bus.imem_address, 32'h20);
    beat_pc.delete(); beat_data.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h1C;
    cyc();
    redirect_valid = 1'b0;
    repeat (6) cyc();
    chk("t4_nbeats", 32'(beat_pc.size()), 32'd1);
    if (beat_pc.size() > 0) begin
      chk("t4_beat_pc", beat_pc[0], 32'h1C);
      chk("t4_beat_data", beat_data[0], 32'h00f768b3);
    end
    chk("t4_rehalted", 32'(halted), 32'd1);

    // Reset with a full queue; start during reset and redirect in IDLE are ignored.
    bus.inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    cyc();
    redirect_valid = 1'b0;
    repeat (3) cyc();
    chk("t5_pre_valid", 32'(bus.inst_valid), 32'd1);
    rst = 1'b1; start = 1'b1;
    cyc();
    chk("t5_valid", 32'(bus.inst_valid), 32'd0);
    chk("t5_data", bus.inst_data, 32'h0);
    chk("t5_pc", bus.inst_pc, 32'h0);
    chk("t5_addr", bus.imem_address, 32'h0);
    cyc();
    rst = 1'b0; start = 1'b0;
    cyc();
    chk("t5_idle_busy", 32'(busy), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h18;
    cyc();
    redirect_valid = 1'b0;
    chk("t5_idle_redirect_addr", bus.imem_address, 32'h0);
    chk("t5_idle_redirect_valid", 32'(bus.inst_valid), 32'd0);
    start = 1'b1; cyc(); cyc(); start = 1'b0;
    repeat (3) cyc();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      start          = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom_range(0, 63);
      bus.inst_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
